// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder tree and its downstream accumulator.
package adder_tree_pkg;

  localparam int ADDER_WIDTH = 17;

  typedef logic [ADDER_WIDTH:0] tree_sum_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Wide enough to hold count maximal tree sums without wrapping.
  function automatic int acc_width(input int adder_width, input int count);
    return adder_width + 1 + $clog2(count);
  endfunction

endpackage

// File: rtl/adder_tree_accumulator_if.sv
// Sample input stream, frame-total output stream and frame abort for the accumulator.
interface adder_tree_accumulator_if #(
  parameter int ADDER_WIDTH = 17,
  parameter int ACC_COUNT   = 16
);
  import adder_tree_pkg::*;

  localparam int ACC_WIDTH = acc_width(ADDER_WIDTH, ACC_COUNT);

  logic                   clear;
  logic                   in_valid;
  logic [ADDER_WIDTH:0]   in_sum;
  logic                   in_ready;
  logic                   out_valid;
  logic [ACC_WIDTH-1:0]   out_acc;
  logic                   out_ready;

  modport master (
    output clear, in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_acc
  );

  modport slave (
    input  clear, in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_acc
  );

endinterface

// File: rtl/adder_tree_accumulator.sv
// Purpose: sums ACC_COUNT consecutive tree results into one frame total held in a one-entry slot.
// Latency: out_valid rises the cycle after the final sample of a frame is accepted.
// Backpressure: only the final sample stalls, while the slot is full and not draining.
module adder_tree_accumulator #(
  parameter int ADDER_WIDTH = adder_tree_pkg::ADDER_WIDTH,
  parameter int ACC_COUNT   = 16
) (
  input logic                        clk,
  input logic                        rst_n,
  adder_tree_accumulator_if.slave    bus
);
  import adder_tree_pkg::*;

  localparam int ACC_WIDTH = acc_width(ADDER_WIDTH, ACC_COUNT);
  localparam int CNT_W     = $clog2(ACC_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_COUNT - 1);

  if (ACC_COUNT < 2) begin : g_bad_count
    $error("adder_tree_accumulator: ACC_COUNT must be at least 2");
  end

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_plus;
  logic [ACC_WIDTH-1:0] out_acc_q;
  logic [CNT_W-1:0]     cnt;
  slot_state_t          slot_q;
  slot_state_t          slot_d;
  logic                 at_last;
  logic                 accept;
  logic                 last;

  assign acc_plus = acc + ACC_WIDTH'(bus.in_sum);
  assign at_last  = (cnt == CNT_LAST);

  // Combinational out_ready -> in_ready path lets back-to-back frames complete without a bubble.
  assign bus.in_ready = !bus.clear && !(at_last && slot_q == SLOT_FULL && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last         = accept && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (bus.clear || last) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_plus;
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_acc_q <= '0;
      slot_q    <= SLOT_EMPTY;
    end else begin
      slot_q <= slot_d;
      if (last) begin
        out_acc_q <= acc_plus;
      end
    end
  end

  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY: if (last) slot_d = SLOT_FULL;
      SLOT_FULL:  if (bus.out_ready && !last) slot_d = SLOT_EMPTY;
      default:    slot_d = SLOT_EMPTY;
    endcase
  end

  assign bus.out_valid = (slot_q == SLOT_FULL);
  assign bus.out_acc   = out_acc_q;

endmodule
